// File: rtl/sample_rate_sequencer_if.sv
// Memory fetch handshake plus output-stage bundle for the sample-rate sequencer.
// The master side is the sequencer; the slave side is the memory/DAC environment.
interface sample_rate_sequencer_if #(
    parameter int unsigned DATA_W = 16
);
    logic              rd_req;
    logic              rd_ack;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] sample_out;
    logic              sample_valid;
    logic              underrun;
    logic              s_clk;

    modport master (
        output rd_req,
        input  rd_ack,
        input  rd_data,
        output sample_out,
        output sample_valid,
        output underrun,
        output s_clk
    );

    modport slave (
        input  rd_req,
        output rd_ack,
        output rd_data,
        input  sample_out,
        input  sample_valid,
        input  underrun,
        input  s_clk
    );
endinterface

// File: rtl/sample_rate_sequencer.sv
// Sample-rate sequencer: programmable tick divider, 50 % frame clock and a one-entry
// prefetch buffer that hands a fetched sample to the output stage exactly on each tick.
module sample_rate_sequencer #(
    parameter int unsigned CNT_W  = 14,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned TERM_0 = 2267,
    parameter int unsigned TERM_1 = 4535,
    parameter int unsigned TERM_2 = 9070,
    parameter int unsigned TERM_3 = 12499
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [1:0]              rate_sel,
    sample_rate_sequencer_if.master bus
);

    typedef enum logic [1:0] {StIdle, StPrime, StWait, StFetch} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  term_q, term_d;
    logic [CNT_W-1:0]  sel_term;
    logic [DATA_W-1:0] sbuf_q, sbuf_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              valid_q, valid_d;
    logic              under_q, under_d;
    logic              sclk_q, sclk_d;
    logic              req;
    logic              accept;
    logic              counting;
    logic              tick;

    always_comb begin
        case (rate_sel)
            2'd0:    sel_term = CNT_W'(TERM_0);
            2'd1:    sel_term = CNT_W'(TERM_1);
            2'd2:    sel_term = CNT_W'(TERM_2);
            default: sel_term = CNT_W'(TERM_3);
        endcase
    end

    // Buffer occupancy is encoded in the state: WAIT means full, FETCH means empty.
    assign req      = (state_q == StPrime) || (state_q == StFetch);
    assign accept   = req && bus.rd_ack;
    assign counting = (state_q == StWait) || (state_q == StFetch);
    assign tick     = counting && (cnt_q == term_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        term_d  = term_q;
        sbuf_d  = sbuf_q;
        out_d   = out_q;
        valid_d = 1'b0;
        under_d = under_q;

        if (!enable) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StPrime;
                    term_d  = sel_term;
                    under_d = 1'b0;
                    cnt_d   = '0;
                end
                StPrime: begin
                    if (accept) begin
                        sbuf_d  = bus.rd_data;
                        state_d = StWait;
                    end
                end
                StWait: begin
                    if (tick) begin
                        out_d   = sbuf_q;
                        valid_d = 1'b1;
                        state_d = StFetch;
                    end
                end
                StFetch: begin
                    if (tick) begin
                        valid_d = 1'b1;
                        // A same-cycle ack bypasses the empty buffer straight to the output.
                        if (accept) begin
                            out_d = bus.rd_data;
                        end else begin
                            under_d = 1'b1;
                        end
                    end else if (accept) begin
                        sbuf_d  = bus.rd_data;
                        state_d = StWait;
                    end
                end
                default: state_d = StIdle;
            endcase

            if (tick) begin
                cnt_d  = '0;
                term_d = sel_term;
            end else if (counting) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        sclk_d = ((state_d == StWait) || (state_d == StFetch)) && (cnt_d <= (term_d >> 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            term_q  <= '0;
            sbuf_q  <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            under_q <= 1'b0;
            sclk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            term_q  <= term_d;
            sbuf_q  <= sbuf_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            under_q <= under_d;
            sclk_q  <= sclk_d;
        end
    end

    assign bus.rd_req       = req;
    assign bus.sample_out   = out_q;
    assign bus.sample_valid = valid_q;
    assign bus.underrun     = under_q;
    assign bus.s_clk        = sclk_q;

endmodule
